pipeline_stall_controller: RTL and testbench

- Central sequencer for the 5-stage RISC-V pipeline's stage registers.
- Merges four requests into one consistent set of per-stage write-enable, flush and bubble controls each cycle, in a fixed priority:
  - data-memory busy
  - branch redirect
  - load-use hazard
  - instruction-memory busy
- Holds multi-cycle stalls via a small FSM.
- Keeps stall/flush statistics and a data-memory timeout flag.

---
 rtl/pipeline_stall_controller_pkg.sv | 43 ++++
 rtl/pipeline_stall_controller_stall_stats_counter.sv | 29 ++
 rtl/pipeline_stall_controller.sv | 135 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline types: sequencer states, stage-control bundle, canned control sets.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LU_STALL,
    ST_DMEM_WAIT
  } state_e;

  // Field order of the per-stage control bundle, IF side first.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_bubble;
  } ctrl_t;

  // RV32I canonical NOP (addi x0, x0, 0) loaded by flushed/bubbled stages.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam ctrl_t CTRL_RUN      = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                      id_ex_we: 1'b1, id_ex_flush: 1'b0, ex_mem_we: 1'b1,
                                      mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_FREEZE   = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                      id_ex_we: 1'b0, id_ex_flush: 1'b0, ex_mem_we: 1'b0,
                                      mem_wb_bubble: 1'b1};
  localparam ctrl_t CTRL_BRANCH   = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                      id_ex_we: 1'b1, id_ex_flush: 1'b1, ex_mem_we: 1'b1,
                                      mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_LOAD_USE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                      id_ex_we: 1'b1, id_ex_flush: 1'b1, ex_mem_we: 1'b1,
                                      mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_IMEM     = '{pc_we: 1'b0, if_id_we: 1'b1, if_id_flush: 1'b1,
                                      id_ex_we: 1'b1, id_ex_flush: 1'b0, ex_mem_we: 1'b1,
                                      mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_RESET    = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
                                      id_ex_we: 1'b0, id_ex_flush: 1'b1, ex_mem_we: 1'b0,
                                      mem_wb_bubble: 1'b1};

endpackage

// File: rtl/pipeline_stall_controller_stall_stats_counter.sv
// Event counter with sync clear, load-to-one and optional saturation.
module stall_stats_counter #(
  parameter int unsigned W        = 32,
  parameter bit          SATURATE = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Clear beats load beats increment; saturating variant holds at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= W'(1);
    end else if (i_inc && !(SATURATE && (r_count == '1))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush sequencer: merges dmem, branch, load-use and imem requests.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  input  logic             imem_busy,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_write_en,
  output logic             id_ex_flush,
  output logic             ex_mem_write_en,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_timeout_err
);

  localparam logic [3:0] LU_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [8:0] TMO     = 9'(MEM_TIMEOUT);

  state_e      r_state;
  state_e      r_ret_state;
  logic [3:0]  r_lu_cnt;
  logic        r_timeout_err;

  state_e      w_eff_state;
  ctrl_t       w_ctrl;
  logic        w_branch;
  logic [7:0]  w_wait_cnt;
  logic [8:0]  w_wait_next;
  logic        w_wait_load;
  logic        w_wait_inc;

  // Priority merge of requests into one control bundle; a finished dmem wait
  // resolves through the saved state in the same cycle.
  always_comb begin
    w_eff_state = (r_state == ST_DMEM_WAIT) ? r_ret_state : r_state;
    w_ctrl      = CTRL_RUN;
    w_branch    = 1'b0;
    if (reset) begin
      w_ctrl = CTRL_RESET;
    end else if (dmem_busy) begin
      w_ctrl = CTRL_FREEZE;
    end else if (branch_taken) begin
      w_ctrl   = CTRL_BRANCH;
      w_branch = 1'b1;
    end else if (w_eff_state == ST_LU_STALL || load_use_hazard) begin
      w_ctrl = CTRL_LOAD_USE;
    end else if (imem_busy) begin
      w_ctrl = CTRL_IMEM;
    end
  end

  // Value wait_cnt will take at this edge while dmem is busy; drives the timeout.
  always_comb begin
    w_wait_load = dmem_busy && (r_state != ST_DMEM_WAIT);
    w_wait_inc  = dmem_busy && (r_state == ST_DMEM_WAIT);
    w_wait_next = w_wait_inc ? ({1'b0, w_wait_cnt} + 9'd1) : 9'd1;
  end

  // Sequencer state, load-use countdown and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_ret_state   <= ST_RUN;
      r_lu_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else if (dmem_busy) begin
      if (r_state != ST_DMEM_WAIT) begin
        r_ret_state <= r_state;
        r_state     <= ST_DMEM_WAIT;
      end
      if (w_wait_next >= TMO) begin
        r_timeout_err <= 1'b1;
      end
    end else if (branch_taken) begin
      r_state  <= ST_RUN;
      r_lu_cnt <= '0;
    end else if (w_eff_state == ST_LU_STALL) begin
      r_lu_cnt <= r_lu_cnt - 4'd1;
      r_state  <= (r_lu_cnt == 4'd1) ? ST_RUN : ST_LU_STALL;
    end else if (load_use_hazard && (LOAD_STALL_CYCLES > 1)) begin
      r_state  <= ST_LU_STALL;
      r_lu_cnt <= LU_INIT;
    end else begin
      r_state <= ST_RUN;
    end
  end

  stall_stats_counter #(.W(CNT_W), .SATURATE(1'b0)) u_stall_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clr   (1'b0),
    .i_load  (1'b0),
    .i_inc   (!w_ctrl.pc_we),
    .o_count (stall_cycles)
  );

  stall_stats_counter #(.W(CNT_W), .SATURATE(1'b0)) u_flush_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clr   (1'b0),
    .i_load  (1'b0),
    .i_inc   (w_branch),
    .o_count (flush_events)
  );

  stall_stats_counter #(.W(8), .SATURATE(1'b1)) u_wait_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clr   (!dmem_busy),
    .i_load  (w_wait_load),
    .i_inc   (w_wait_inc),
    .o_count (w_wait_cnt)
  );

  assign pc_write_en     = w_ctrl.pc_we;
  assign if_id_write_en  = w_ctrl.if_id_we;
  assign if_id_flush     = w_ctrl.if_id_flush;
  assign id_ex_write_en  = w_ctrl.id_ex_we;
  assign id_ex_flush     = w_ctrl.id_ex_flush;
  assign ex_mem_write_en = w_ctrl.ex_mem_we;
  assign mem_wb_bubble   = w_ctrl.mem_wb_bubble;
  assign mem_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench: two instances (1-cycle and 3-cycle load stall, short timeout).
module tb_pipeline_stall_controller;

  // Control vector order: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble}
  localparam logic [6:0] C_RUN = 7'b1101010;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_LU  = 7'b0001110;
  localparam logic [6:0] C_IM  = 7'b0111010;
  localparam logic [6:0] C_RST = 7'b0010101;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lu = 1'b0, br = 1'b0, dm = 1'b0, im = 1'b0;

  logic        a_pc, a_ifwe, a_iffl, a_idwe, a_idfl, a_exwe, a_bub, a_err;
  logic [31:0] a_stall, a_flush;
  logic        b_pc, b_ifwe, b_iffl, b_idwe, b_idfl, b_exwe, b_bub, b_err;
  logic [31:0] b_stall, b_flush;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .load_use_hazard(lu), .branch_taken(br),
    .dmem_busy(dm), .imem_busy(im),
    .pc_write_en(a_pc), .if_id_write_en(a_ifwe), .if_id_flush(a_iffl),
    .id_ex_write_en(a_idwe), .id_ex_flush(a_idfl), .ex_mem_write_en(a_exwe),
    .mem_wb_bubble(a_bub), .stall_cycles(a_stall), .flush_events(a_flush),
    .mem_timeout_err(a_err)
  );

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(5), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset), .load_use_hazard(lu), .branch_taken(br),
    .dmem_busy(dm), .imem_busy(im),
    .pc_write_en(b_pc), .if_id_write_en(b_ifwe), .if_id_flush(b_iffl),
    .id_ex_write_en(b_idwe), .id_ex_flush(b_idfl), .ex_mem_write_en(b_exwe),
    .mem_wb_bubble(b_bub), .stall_cycles(b_stall), .flush_events(b_flush),
    .mem_timeout_err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check both control bundles mid-cycle, then clock.
  task automatic cyc(input string tag, input logic i_rst, input logic i_br, input logic i_lu,
                     input logic i_dm, input logic i_im,
                     input logic [6:0] exp1, input logic [6:0] exp3);
    reset = i_rst; br = i_br; lu = i_lu; dm = i_dm; im = i_im;
    @(negedge clk);
    check({tag, "/ctrl1"}, {25'd0, a_pc, a_ifwe, a_iffl, a_idwe, a_idfl, a_exwe, a_bub}, {25'd0, exp1});
    check({tag, "/ctrl3"}, {25'd0, b_pc, b_ifwe, b_iffl, b_idwe, b_idfl, b_exwe, b_bub}, {25'd0, exp3});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RST, C_RST);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    check("rst/stall1", a_stall, 32'd0);
    check("rst/flush1", a_flush, 32'd0);
    check("rst/err3", {31'd0, b_err}, 32'd0);

    // Idle run
    for (int i = 0; i < 10; i++) cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_RUN);
    check("idle/stall1", a_stall, 32'd0);
    check("idle/flush1", a_flush, 32'd0);

    // Single hazard pulse: 1 bubble vs 3 bubbles
    cyc("lu0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_LU, C_LU);
    cyc("lu1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_LU);
    cyc("lu2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_LU);
    cyc("lu3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_RUN);
    check("lu/stall1", a_stall, 32'd1);
    check("lu/stall3", b_stall, 32'd3);

    // Branch on second stall cycle abandons the load-use stall
    do_reset();
    cyc("lubr0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_LU, C_LU);
    cyc("lubr1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_BR, C_BR);
    cyc("lubr2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_RUN);
    check("lubr/stall3", b_stall, 32'd1);
    check("lubr/flush3", b_flush, 32'd1);

    // dmem freeze in the middle of a load-use stall
    do_reset();
    cyc("ludm0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_LU, C_LU);
    for (int i = 0; i < 4; i++) cyc("ludm_frz", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, C_FRZ);
    cyc("ludm5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_LU);
    cyc("ludm6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_LU);
    cyc("ludm7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_RUN);
    check("ludm/stall3", b_stall, 32'd7);
    check("ludm/stall1", a_stall, 32'd5);
    check("ludm/err3", {31'd0, b_err}, 32'd0);

    // All lower requests together: branch wins; then imem alone
    do_reset();
    cyc("all", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, C_BR, C_BR);
    check("all/stall1", a_stall, 32'd0);
    check("all/flush1", a_flush, 32'd1);
    cyc("imem", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_IM, C_IM);
    check("imem/stall3", b_stall, 32'd1);

    // Timeout: 8 busy cycles, release with a hazard in the same cycle
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      cyc("tmo_frz", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, C_FRZ);
      if (k == 4) check("tmo/err3_k4", {31'd0, b_err}, 32'd0);
      if (k == 5) check("tmo/err3_k5", {31'd0, b_err}, 32'd1);
    end
    cyc("tmo_rel", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_LU, C_LU);
    cyc("tmo_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_LU);
    check("tmo/err3_after", {31'd0, b_err}, 32'd1);
    check("tmo/err1", {31'd0, a_err}, 32'd0);
    check("tmo/stall1", a_stall, 32'd9);
    cyc("tmo_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_LU);
    cyc("tmo_c", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_RUN);
    check("tmo/stall3", b_stall, 32'd11);

    // Reset mid-stall leaves no residual bubble and clears the error
    cyc("rs0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_LU, C_LU);
    do_reset();
    check("rs/err3", {31'd0, b_err}, 32'd0);
    check("rs/stall3", b_stall, 32'd0);
    cyc("rs1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, C_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
